// File: rtl/dsa_pixel_store_simd.sv
// rtl/dsa_pixel_store_simd.sv - SIMD output-pixel vector store unit
//
// Accepts vectors of SIMD_WIDTH 8-bit pixels tagged with a destination (x, y)
// and writes the in-bounds, enabled lanes one byte per cycle into the
// destination image memory. A pending slot in front of the active vector lets
// the producer hand over the next vector while the current one drains.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   in_valid/in_ready   input vector handshake (transfer on both high at clk edge)
//   in_x, in_y          destination coordinate of lane 0
//   in_pix[SIMD_WIDTH]  lane pixel values
//   in_mask             per-lane write enable
//   dst_base_addr       destination image base address (captured per vector)
//   dst_width           destination image width        (captured per vector)
//   dst_height          destination image height       (captured per vector)
//   mem_write_en        byte write request
//   mem_addr, mem_wdata write address / data, held stable while stalled
//   mem_wr_ready        memory accepts the presented write this cycle
//   store_done          one-cycle pulse when a vector has been fully handled
//   lanes_written       writes issued for that vector (zero outside store_done)
//   write_count         total accepted writes since reset, wrapping
//   busy                vector in flight or pending slot occupied

module dsa_pixel_store_simd #(
  parameter int ADDR_WIDTH = 18,
  parameter int SIMD_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [15:0]                       in_x,
  input  logic [15:0]                       in_y,
  input  logic [7:0]                        in_pix [SIMD_WIDTH],
  input  logic [SIMD_WIDTH-1:0]             in_mask,
  input  logic [ADDR_WIDTH-1:0]             dst_base_addr,
  input  logic [15:0]                       dst_width,
  input  logic [15:0]                       dst_height,
  output logic                              mem_write_en,
  output logic [ADDR_WIDTH-1:0]             mem_addr,
  output logic [7:0]                        mem_wdata,
  input  logic                              mem_wr_ready,
  output logic                              store_done,
  output logic [$clog2(SIMD_WIDTH+1)-1:0]   lanes_written,
  output logic [31:0]                       write_count,
  output logic                              busy
);

  localparam int LW = $clog2(SIMD_WIDTH + 1);
  localparam int IW = $clog2(SIMD_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t state;

  // Pending slot: filled by the input handshake, emptied into the active set.
  logic                  pend_valid;
  logic [15:0]           pend_x;
  logic [15:0]           pend_y;
  logic [7:0]            pend_pix [SIMD_WIDTH];
  logic [SIMD_WIDTH-1:0] pend_mask;
  logic [ADDR_WIDTH-1:0] pend_base;
  logic [15:0]           pend_w;
  logic [15:0]           pend_h;

  // Active vector being drained to memory.
  logic [15:0]           act_x;
  logic [15:0]           act_y;
  logic [7:0]            act_pix [SIMD_WIDTH];
  logic [SIMD_WIDTH-1:0] act_mask;
  logic [ADDR_WIDTH-1:0] act_base;
  logic [15:0]           act_w;
  logic [15:0]           act_h;

  logic [ADDR_WIDTH-1:0] row_base;
  logic [SIMD_WIDTH-1:0] remaining;
  logic [LW-1:0]         lane_cnt;
  logic [31:0]           wr_cnt;

  logic                  accept;
  logic                  load_pend;
  logic                  fire;
  logic [SIMD_WIDTH-1:0] lane_ok;
  logic [SIMD_WIDTH-1:0] write_set;
  logic [SIMD_WIDTH-1:0] rem_clr;
  logic [IW-1:0]         lane;
  logic [ADDR_WIDTH-1:0] row_base_n;
  logic [ADDR_WIDTH-1:0] cur_addr;

  // in_ready only looks at the registered slot state, so a slot that drains
  // at the same edge does not let a new vector in until the next cycle.
  assign in_ready  = !pend_valid;
  assign accept    = in_valid && !pend_valid;
  assign load_pend = pend_valid && ((state == ST_IDLE) || (state == ST_DONE));
  assign fire      = (state == ST_WRITE) && mem_wr_ready;

  // Lane bounds test uses a 17-bit compare so x+i cannot wrap back in range.
  always_comb begin
    lane_ok = '0;
    for (int i = 0; i < SIMD_WIDTH; i++) begin
      lane_ok[i] = (({1'b0, act_x} + 17'(i)) < {1'b0, act_w}) && (act_y < act_h);
    end
  end

  assign write_set = act_mask & lane_ok;

  // Lowest set bit of remaining selects the lane presented to memory.
  always_comb begin
    lane = '0;
    for (int i = SIMD_WIDTH - 1; i >= 0; i--) begin
      if (remaining[i]) begin
        lane = IW'(i);
      end
    end
  end

  // Clearing the lowest set bit removes exactly the lane just written.
  assign rem_clr    = remaining & (remaining - SIMD_WIDTH'(1));

  // All address arithmetic is done modulo 2^ADDR_WIDTH.
  assign row_base_n = act_base + (ADDR_WIDTH'(act_y) * ADDR_WIDTH'(act_w));
  assign cur_addr   = row_base + ADDR_WIDTH'(act_x) + ADDR_WIDTH'(lane);

  // Outputs decode state registers only; nothing from the inputs reaches them.
  assign mem_write_en  = (state == ST_WRITE);
  assign mem_addr      = (state == ST_WRITE) ? cur_addr : '0;
  assign mem_wdata     = (state == ST_WRITE) ? act_pix[lane] : 8'd0;
  assign store_done    = (state == ST_DONE);
  assign lanes_written = (state == ST_DONE) ? lane_cnt : '0;
  assign write_count   = wr_cnt;
  assign busy          = (state != ST_IDLE) || pend_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      pend_valid <= 1'b0;
      pend_x     <= '0;
      pend_y     <= '0;
      pend_pix   <= '{default: '0};
      pend_mask  <= '0;
      pend_base  <= '0;
      pend_w     <= '0;
      pend_h     <= '0;
      act_x      <= '0;
      act_y      <= '0;
      act_pix    <= '{default: '0};
      act_mask   <= '0;
      act_base   <= '0;
      act_w      <= '0;
      act_h      <= '0;
      row_base   <= '0;
      remaining  <= '0;
      lane_cnt   <= '0;
      wr_cnt     <= '0;
    end else begin
      // accept and load_pend are mutually exclusive: accept needs an empty slot.
      if (accept) begin
        pend_valid <= 1'b1;
        pend_x     <= in_x;
        pend_y     <= in_y;
        pend_pix   <= in_pix;
        pend_mask  <= in_mask;
        pend_base  <= dst_base_addr;
        pend_w     <= dst_width;
        pend_h     <= dst_height;
      end else if (load_pend) begin
        pend_valid <= 1'b0;
      end

      if (load_pend) begin
        act_x    <= pend_x;
        act_y    <= pend_y;
        act_pix  <= pend_pix;
        act_mask <= pend_mask;
        act_base <= pend_base;
        act_w    <= pend_w;
        act_h    <= pend_h;
        lane_cnt <= '0;
      end

      if (fire) begin
        wr_cnt <= wr_cnt + 32'd1;
      end

      case (state)
        ST_IDLE: begin
          if (pend_valid) begin
            state <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          row_base  <= row_base_n;
          remaining <= write_set;
          state     <= (write_set == '0) ? ST_DONE : ST_WRITE;
        end
        ST_WRITE: begin
          if (mem_wr_ready) begin
            remaining <= rem_clr;
            lane_cnt  <= lane_cnt + LW'(1);
            if (rem_clr == '0) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= pend_valid ? ST_ADDR : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsa_pixel_store_simd.sv
// tb/tb_dsa_pixel_store_simd.sv - self-checking bench for dsa_pixel_store_simd

module tb_dsa_pixel_store_simd;

  localparam int AW = 18;
  localparam int SW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [15:0]   in_x;
  logic [15:0]   in_y;
  logic [7:0]    in_pix [SW];
  logic [SW-1:0] in_mask;
  logic [AW-1:0] dst_base_addr;
  logic [15:0]   dst_width;
  logic [15:0]   dst_height;
  logic          mem_write_en;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_wr_ready;
  logic          store_done;
  logic [2:0]    lanes_written;
  logic [31:0]   write_count;
  logic          busy;

  always #5 clk = ~clk;

  dsa_pixel_store_simd #(.ADDR_WIDTH(AW), .SIMD_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_pix(in_pix), .in_mask(in_mask),
    .dst_base_addr(dst_base_addr), .dst_width(dst_width), .dst_height(dst_height),
    .mem_write_en(mem_write_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr_ready(mem_wr_ready),
    .store_done(store_done), .lanes_written(lanes_written),
    .write_count(write_count), .busy(busy)
  );

  typedef struct {
    logic [15:0]         x, y, w, h;
    logic [AW-1:0]       base;
    logic [SW-1:0]       mask;
    logic [SW-1:0][7:0]  pix;
    int                  n;
    logic [SW-1:0][AW-1:0] ea;
    logic [SW-1:0][7:0]  ed;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  vec_t   tbl [6];
  wr_t    exp_q [$];
  int     exp_done_q [$];
  wr_t    cap_q [$];
  int     wcyc_q [$];
  int     dcyc_q [$];

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  int     acc_cyc = 0;
  int     done_cnt = 0;
  int     last_lanes = 0;
  int     wen_cycles = 0;
  longint model_wc = 0;
  bit     stalled_prev = 0;
  logic [AW-1:0] prev_a;
  logic [7:0]    prev_d;

  bit     bp_mode = 0;
  bit     rand_rdy = 0;
  int     stall_cnt = 0;
  logic [AW-1:0] bp_addr = '0;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: every in-bounds enabled lane produces one byte write at
  // base + y*width + x + lane, modulo the address space, in lane order.
  function automatic void model_vec();
    int n = 0;
    for (int i = 0; i < SW; i++) begin
      if (in_mask[i] && (int'(in_x) + i < int'(dst_width)) && (in_y < dst_height)) begin
        longint a;
        wr_t e;
        a = (longint'(dst_base_addr) + longint'(in_y) * longint'(dst_width)
             + longint'(in_x) + i) % (longint'(1) << AW);
        e.a = AW'(a);
        e.d = in_pix[i];
        exp_q.push_back(e);
        n++;
      end
    end
    exp_done_q.push_back(n);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: samples mid-cycle, the values that the next rising edge acts on.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      stalled_prev = 0;
    end else begin
      chk(write_count == 32'(model_wc), "write_count", write_count, model_wc);
      if (stalled_prev) begin
        chk(mem_write_en && mem_addr == prev_a && mem_wdata == prev_d, "bp_hold",
            {mem_write_en, mem_addr, mem_wdata}, {1'b1, prev_a, prev_d});
      end
      if (mem_write_en) begin
        wen_cycles++;
        if (mem_wr_ready) begin
          if (exp_q.size() == 0) begin
            chk(0, "unexpected_write", mem_addr, 0);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk(mem_addr == e.a && mem_wdata == e.d, "write_addr_data",
                {mem_addr, mem_wdata}, {e.a, e.d});
          end
          cap_q.push_back({mem_addr, mem_wdata});
          wcyc_q.push_back(cyc);
          model_wc++;
        end
      end
      stalled_prev = mem_write_en && !mem_wr_ready;
      prev_a = mem_addr;
      prev_d = mem_wdata;
      if (store_done) begin
        done_cnt++;
        last_lanes = int'(lanes_written);
        dcyc_q.push_back(cyc);
        if (exp_done_q.size() == 0) begin
          chk(0, "unexpected_done", lanes_written, 0);
        end else begin
          int n;
          n = exp_done_q.pop_front();
          chk(int'(lanes_written) == n, "lanes_written", lanes_written, n);
        end
      end else begin
        chk(lanes_written == 3'd0, "lanes_idle", lanes_written, 0);
      end
      if (in_valid && in_ready) begin
        model_vec();
        acc_cyc = cyc;
      end
    end
  end

  // Memory ready driver: optional targeted stall on one address, or random.
  initial forever begin
    @(posedge clk);
    #1;
    if (bp_mode && mem_write_en && mem_addr == bp_addr && stall_cnt < 3) begin
      mem_wr_ready = 1'b0;
      stall_cnt++;
    end else if (rand_rdy) begin
      mem_wr_ready = ($urandom_range(3) != 0);
    end else begin
      mem_wr_ready = 1'b1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // Holds in_valid until the vector is taken, so consecutive calls are back to back.
  task automatic send(input vec_t v);
    int n = 0;
    bit acc = 0;
    in_x = v.x; in_y = v.y; in_mask = v.mask;
    dst_base_addr = v.base; dst_width = v.w; dst_height = v.h;
    for (int i = 0; i < SW; i++) in_pix[i] = v.pix[i];
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk(0, "accept_timeout", n, 100);
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(done_cnt != d0, "done_timeout", n, 60);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(n < 2000, "idle_timeout", n, 2000);
    chk(exp_q.size() == 0 && exp_done_q.size() == 0, "queues_drained",
        exp_q.size() + exp_done_q.size(), 0);
  endtask

  task automatic clear_caps();
    cap_q.delete();
    wcyc_q.delete();
    dcyc_q.delete();
  endtask

  task automatic apply_checked(input vec_t v, input string name);
    int d0;
    clear_caps();
    d0 = done_cnt;
    send(v);
    in_valid = 1'b0;
    wait_done(d0);
    chk(cap_q.size() == v.n, {name, "_count"}, cap_q.size(), v.n);
    for (int j = 0; j < v.n && j < cap_q.size(); j++) begin
      chk(cap_q[j].a == v.ea[j] && cap_q[j].d == v.ed[j], {name, "_write"},
          {cap_q[j].a, cap_q[j].d}, {v.ea[j], v.ed[j]});
    end
    chk(last_lanes == v.n, {name, "_lanes"}, last_lanes, v.n);
  endtask

  initial begin
    int t3;
    int acc3;
    int d0;
    vec_t r;

    // full vector
    tbl[0] = '{x:16'd10, y:16'd2, w:16'd512, h:16'd512, base:18'h100, mask:4'b1111,
               pix:{8'd44, 8'd33, 8'd22, 8'd11}, n:4,
               ea:{18'h50D, 18'h50C, 18'h50B, 18'h50A}, ed:{8'd44, 8'd33, 8'd22, 8'd11}};
    // right-edge clip
    tbl[1] = '{x:16'd510, y:16'd0, w:16'd512, h:16'd512, base:18'h0, mask:4'b1111,
               pix:{8'd4, 8'd3, 8'd2, 8'd1}, n:2,
               ea:{18'h0, 18'h0, 18'h1FF, 18'h1FE}, ed:{8'd0, 8'd0, 8'd2, 8'd1}};
    // row below the image
    tbl[2] = '{x:16'd0, y:16'd512, w:16'd512, h:16'd512, base:18'h0, mask:4'b1111,
               pix:{8'd4, 8'd3, 8'd2, 8'd1}, n:0, ea:'0, ed:'0};
    // sparse mask
    tbl[3] = '{x:16'd10, y:16'd2, w:16'd512, h:16'd512, base:18'h100, mask:4'b1010,
               pix:{8'd8, 8'd7, 8'd6, 8'd5}, n:2,
               ea:{18'h0, 18'h0, 18'h50D, 18'h50B}, ed:{8'd0, 8'd0, 8'd8, 8'd6}};
    // address wrap
    tbl[4] = '{x:16'd0, y:16'd0, w:16'd512, h:16'd512, base:18'h3FFFE, mask:4'b1111,
               pix:{8'd12, 8'd11, 8'd10, 8'd9}, n:4,
               ea:{18'h00001, 18'h00000, 18'h3FFFF, 18'h3FFFE}, ed:{8'd12, 8'd11, 8'd10, 8'd9}};
    // zero width
    tbl[5] = '{x:16'd0, y:16'd0, w:16'd0, h:16'd512, base:18'h40, mask:4'b1111,
               pix:{8'd4, 8'd3, 8'd2, 8'd1}, n:0, ea:'0, ed:'0};

    rst = 1'b1;
    in_valid = 1'b0; in_x = '0; in_y = '0; in_mask = '0;
    dst_base_addr = '0; dst_width = '0; dst_height = '0;
    for (int i = 0; i < SW; i++) in_pix[i] = '0;
    mem_wr_ready = 1'b1;
    #2;
    chk(in_ready == 1'b1 && busy == 1'b0, "reset_ready_busy", {in_ready, busy}, 2'b10);
    chk(mem_write_en == 0 && mem_addr == 0 && mem_wdata == 0, "reset_mem",
        {mem_write_en, mem_addr, mem_wdata}, 0);
    chk(store_done == 0 && lanes_written == 0 && write_count == 0, "reset_done_cnt",
        {store_done, lanes_written, write_count}, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk(in_ready == 1'b1 && busy == 1'b0 && mem_write_en == 1'b0, "post_reset",
        {in_ready, busy, mem_write_en}, 3'b100);

    // Table of directed vectors, memory always ready.
    for (int k = 0; k < 6; k++) begin
      apply_checked(tbl[k], $sformatf("vec%0d", k));
      wait_idle();
    end

    // Latency: accept, idle, addr, four writes, done.
    apply_checked(tbl[0], "latency");
    chk(wcyc_q.size() == 4 && wcyc_q[0] == acc_cyc + 3, "first_write_latency",
        wcyc_q.size() > 0 ? wcyc_q[0] - acc_cyc : -1, 3);
    chk(wcyc_q.size() == 4 && wcyc_q[3] == acc_cyc + 6, "consecutive_writes",
        wcyc_q.size() > 3 ? wcyc_q[3] - acc_cyc : -1, 6);
    chk(dcyc_q.size() == 1 && dcyc_q[0] == acc_cyc + 7, "done_latency",
        dcyc_q.size() > 0 ? dcyc_q[0] - acc_cyc : -1, 7);
    wait_idle();

    // Backpressure on lane 1 for three cycles.
    bp_mode = 1; bp_addr = 18'h50B; stall_cnt = 0; wen_cycles = 0;
    apply_checked(tbl[0], "backpressure");
    chk(stall_cnt == 3, "bp_stalls", stall_cnt, 3);
    chk(wen_cycles == 7, "bp_write_en_cycles", wen_cycles, 7);
    bp_mode = 0;
    wait_idle();

    // Three vectors back to back through the two-entry buffer.
    clear_caps();
    send(tbl[0]);
    send(tbl[4]);
    t3 = cyc;
    send(tbl[0]);
    acc3 = acc_cyc;
    in_valid = 1'b0;
    wait_idle();
    chk(cap_q.size() == 12, "buffer_write_total", cap_q.size(), 12);
    chk(acc3 - t3 == 5, "third_vector_wait", acc3 - t3, 5);
    chk(dcyc_q.size() == 3, "buffer_done_total", dcyc_q.size(), 3);
    chk(wcyc_q.size() > 4 && dcyc_q.size() > 0 && wcyc_q[4] == dcyc_q[0] + 2,
        "done_to_addr_direct", wcyc_q.size() > 4 && dcyc_q.size() > 0 ? wcyc_q[4] - dcyc_q[0] : -1, 2);

    // Reset in the middle of a vector.
    clear_caps();
    send(tbl[0]);
    in_valid = 1'b0;
    begin
      int n = 0;
      while (cap_q.size() < 2 && n < 40) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk(cap_q.size() >= 2, "mid_reset_reach", cap_q.size(), 2);
    end
    rst = 1'b1;
    #1;
    chk(mem_write_en == 1'b0 && store_done == 1'b0, "mid_reset_outputs",
        {mem_write_en, store_done}, 0);
    chk(in_ready == 1'b1 && busy == 1'b0, "mid_reset_ready", {in_ready, busy}, 2'b10);
    chk(write_count == 32'd0, "mid_reset_count", write_count, 0);
    exp_q.delete();
    exp_done_q.delete();
    model_wc = 0;
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk(done_cnt == d0, "no_done_after_reset", done_cnt - d0, 0);
    apply_checked(tbl[0], "after_reset");
    chk(write_count == 32'd4, "after_reset_count", write_count, 4);
    wait_idle();

    // Random vectors with random memory backpressure against the model.
    rand_rdy = 1;
    for (int k = 0; k < 60; k++) begin
      r.w = 16'($urandom_range(0, 40));
      r.h = 16'($urandom_range(0, 10));
      r.x = 16'($urandom_range(0, int'(r.w) + 5));
      r.y = 16'($urandom_range(0, int'(r.h) + 2));
      r.base = AW'($urandom);
      r.mask = SW'($urandom);
      r.pix = 32'($urandom);
      r.n = 0; r.ea = '0; r.ed = '0;
      send(r);
      if ($urandom_range(3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 6)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    wait_idle();
    rand_rdy = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
